// File: rtl/branch_update_sched.sv
// branch_update_sched: queues resolved-branch outcomes and feeds them to the
// global-history predictor's single update port. Fetch lookups win over
// updates, and a starvation counter forces an update after STARVE_MAX
// consecutive denied cycles.
// Optional feature macro: BRANCH_UPD_SCHED_BYPASS_EN. When it is defined, an
// outcome that arrives while the FIFO is empty and no lookup or flush is
// active is issued in the same cycle without being written to the FIFO.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | FIFO empty
// S_PEND  | entries queued, lookups currently winning the port
// S_FORCE | starvation limit reached, head issues regardless of lookups
module branch_update_sched #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          upd_req_val,
    output logic                          upd_req_rdy,
    input  logic                          upd_req_taken,
    input  logic                          lookup_val,
    output logic                          lookup_rdy,
    input  logic                          flush,
    output logic                          pred_update_en,
    output logic                          pred_update_val,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [DEPTH-1:0] mem;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_next;
    logic [SW-1:0]   starve_cnt, starve_next;

    logic empty, full, head, force_upd, fifo_issue, bypass, enq_fifo;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign head  = empty ? 1'b0 : mem[rd_ptr];

    // The FORCE state is entered exactly when the FIFO is non-empty and the
    // starvation counter sits at its limit, so it doubles as the force flag.
    assign force_upd  = (state == S_FORCE);
    assign fifo_issue = !empty && !flush && (!lookup_val || force_upd);

`ifdef BRANCH_UPD_SCHED_BYPASS_EN
    assign bypass = empty && !flush && !lookup_val && upd_req_val;
`else
    assign bypass = 1'b0;
`endif

    assign upd_req_rdy     = !full && !flush;
    assign enq_fifo        = upd_req_val && upd_req_rdy && !bypass;
    assign pred_update_en  = fifo_issue || bypass;
    assign pred_update_val = bypass ? upd_req_taken : head;
    assign lookup_rdy      = !(pred_update_en && lookup_val);
    assign occupancy       = count;

    // Next count, starvation counter and FSM state from this cycle's actions.
    always_comb begin
        count_next  = count;
        starve_next = starve_cnt;
        state_next  = state;

        case ({enq_fifo, fifo_issue})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase

        if (flush || empty || fifo_issue)
            starve_next = '0;
        else if (starve_cnt != STARVE_LIM)
            starve_next = starve_cnt + SW'(1);

        if (flush) begin
            count_next  = '0;
            starve_next = '0;
        end

        if (count_next == '0)
            state_next = S_IDLE;
        else if (starve_next == STARVE_LIM)
            state_next = S_FORCE;
        else
            state_next = S_PEND;
    end

    // State, pointers, counters and outcome storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            mem        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            starve_cnt <= starve_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (enq_fifo) begin
                    mem[wr_ptr] <= upd_req_taken;
                    wr_ptr      <= wr_ptr + PW'(1);
                end
                if (fifo_issue)
                    rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule
